// File: rtl/binary_maxpool_stage.sv
// binary_maxpool_stage
// Reads binary feature maps from the convolution engine's output SRAM. Each map is
// 2x2 stride-2 max-pooled (bitwise OR over each window), and the result is written to a
// second SRAM. Maps are processed back to back until a terminator header is read. The
// stage then writes a single 0xFFFF terminator word and returns to idle.
//
// Ports:
//   clk              sole clock, rising edge
//   reset            asynchronous, active-high reset
//   pool_run         start request, sampled in idle only
//   pool_busy        high from the cycle after a run is accepted until the job ends
//   pool_rd_address  input-SRAM read address (registered)
//   pool_rd_data     input-SRAM read data, valid the cycle after its address
//   pool_wr_address  output-SRAM write address (registered)
//   pool_wr_data     output-SRAM write data (registered)
//   pool_wr_enable   output-SRAM write strobe, one word per high cycle
module binary_maxpool_stage #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pool_run,
  output logic              pool_busy,
  output logic [ADDR_W-1:0] pool_rd_address,
  input  logic [DATA_W-1:0] pool_rd_data,
  output logic [ADDR_W-1:0] pool_wr_address,
  output logic [DATA_W-1:0] pool_wr_data,
  output logic              pool_wr_enable
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrRd,
    StHdrChk,
    StRowA,
    StRowB,
    StPoolWr,
    StTermWr
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;   // next output address
  logic [ADDR_W-1:0]  base_q, base_d;       // current map's header address
  logic [N_W-1:0]     n_q, n_d;
  logic [N_W-1:0]     p_q, p_d;
  logic [N_W-1:0]     row_q, row_d;         // pooled row index r
  logic [DATA_W-1:0]  row_a_q, row_a_d;
  logic [DATA_W-1:0]  row_b_q, row_b_d;

  logic [N_W-1:0]     hdr_n;
  logic               hdr_term;
  logic [ADDR_W-1:0]  next_base;
  logic [DATA_W-1:0]  pooled;

  assign hdr_n    = pool_rd_data[N_W-1:0];
  assign hdr_term = (pool_rd_data == '1) || (pool_rd_data[DATA_W-1:N_W] != '0) ||
                    (hdr_n < N_W'(2));
  assign next_base = base_q + ADDR_W'(n_q) + ADDR_W'(1);

  // Column pairs beyond P are dropped, so input bits >= N never reach the output.
  always_comb begin
    pooled = '0;
    for (int j = 0; j < int'(DATA_W / 2); j++) begin
      if (j < int'(p_q)) begin
        pooled[j] = row_a_q[2*j] | row_a_q[2*j+1] | row_b_q[2*j] | row_b_q[2*j+1];
      end
    end
  end

  // Read addresses run one cycle ahead of the state that consumes the data:
  // HDR_CHK presents row 2r, ROW_A presents row 2r+1, and the address of row 2r+2
  // is held through ROW_B/POOL_WR so the next ROW_A finds its data ready.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    base_d    = base_q;
    n_d       = n_q;
    p_d       = p_q;
    row_d     = row_q;
    row_a_d   = row_a_q;
    row_b_d   = row_b_q;

    unique case (state_q)
      StIdle: begin
        // Busy stays high through the terminator strobe cycle, falling one cycle later.
        busy_d = pool_run;
        if (pool_run) begin
          state_d   = StHdrRd;
          base_d    = '0;
          rd_addr_d = '0;
          wr_ptr_d  = '0;
        end
      end
      StHdrRd: begin
        rd_addr_d = base_q + ADDR_W'(1);
        state_d   = StHdrChk;
      end
      StHdrChk: begin
        if (hdr_term) begin
          state_d = StTermWr;
        end else begin
          n_d       = hdr_n;
          p_d       = hdr_n >> 1;
          row_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = wr_ptr_q;
          wr_data_d = DATA_W'(hdr_n >> 1);
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          state_d   = StRowA;
        end
      end
      StRowA: begin
        row_a_d   = pool_rd_data;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        state_d   = StRowB;
      end
      StRowB: begin
        row_b_d = pool_rd_data;
        state_d = StPoolWr;
      end
      StPoolWr: begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr_q;
        wr_data_d = pooled;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        if (row_q == p_q - N_W'(1)) begin
          base_d    = next_base;
          rd_addr_d = next_base;
          state_d   = StHdrRd;
        end else begin
          row_d     = row_q + N_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          state_d   = StRowA;
        end
      end
      StTermWr: begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr_q;
        wr_data_d = '1;
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      wr_ptr_q  <= '0;
      base_q    <= '0;
      n_q       <= '0;
      p_q       <= '0;
      row_q     <= '0;
      row_a_q   <= '0;
      row_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      wr_ptr_q  <= wr_ptr_d;
      base_q    <= base_d;
      n_q       <= n_d;
      p_q       <= p_d;
      row_q     <= row_d;
      row_a_q   <= row_a_d;
      row_b_q   <= row_b_d;
    end
  end

  assign pool_busy       = busy_q;
  assign pool_rd_address = rd_addr_q;
  assign pool_wr_address = wr_addr_q;
  assign pool_wr_data    = wr_data_q;
  assign pool_wr_enable  = wr_en_q;

endmodule

// File: tb/tb_binary_maxpool_stage.sv
module tb_binary_maxpool_stage;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int N_W    = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              pool_run;
  logic              pool_busy;
  logic [ADDR_W-1:0] pool_rd_address;
  logic [DATA_W-1:0] pool_rd_data = '0;
  logic [ADDR_W-1:0] pool_wr_address;
  logic [DATA_W-1:0] pool_wr_data;
  logic              pool_wr_enable;

  binary_maxpool_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_W(N_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .pool_run       (pool_run),
    .pool_busy      (pool_busy),
    .pool_rd_address(pool_rd_address),
    .pool_rd_data   (pool_rd_data),
    .pool_wr_address(pool_wr_address),
    .pool_wr_data   (pool_wr_data),
    .pool_wr_enable (pool_wr_enable)
  );

  always #5 clk = ~clk;

  // Input SRAM with one-cycle read latency; output writes logged in order.
  logic [15:0] in_mem [DEPTH];
  logic [27:0] got_q[$];
  logic [27:0] exp_q[$];

  always @(posedge clk) pool_rd_data <= in_mem[pool_rd_address];
  always @(posedge clk) if (pool_wr_enable === 1'b1) got_q.push_back({pool_wr_address, pool_wr_data});

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] rows [4];
    int          nexp;
    logic [15:0] exp [3];
  } vec_t;

  vec_t tbl[9];

  function automatic vec_t mk(input logic [15:0] h, input logic [15:0] r0, input logic [15:0] r1,
                              input logic [15:0] r2, input logic [15:0] r3, input int ne,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    vec_t v;
    v.hdr = h;
    v.rows[0] = r0; v.rows[1] = r1; v.rows[2] = r2; v.rows[3] = r3;
    v.nexp = ne;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) in_mem[i] = 16'hFFFF;
  endtask

  task automatic add_exp(input int addr, input logic [15:0] d);
    exp_q.push_back({12'(addr % DEPTH), d});
  endtask

  // Reference: walk the maps in memory and pool each 2x2 window arithmetically.
  task automatic build_expected();
    int base, k, n, p;
    logic [15:0] h, a, b, v;
    bit done;
    exp_q.delete();
    base = 0; k = 0; done = 0;
    for (int m = 0; m < 256 && !done; m++) begin
      h = in_mem[base];
      n = int'(h[4:0]);
      if (h[15:5] != 0 || n < 2) begin
        add_exp(k, 16'hFFFF);
        done = 1;
      end else begin
        p = n / 2;
        add_exp(k, 16'(p)); k++;
        for (int r = 0; r < p; r++) begin
          a = in_mem[(base + 1 + 2 * r) % DEPTH];
          b = in_mem[(base + 2 + 2 * r) % DEPTH];
          v = '0;
          for (int j = 0; j < p; j++) v[j] = a[2*j] | a[2*j+1] | b[2*j] | b[2*j+1];
          add_exp(k, v); k++;
        end
        base = (base + 1 + n) % DEPTH;
      end
    end
  endtask

  task automatic compare_log(input string name);
    int lim;
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      check($sformatf("%s_addr%0d", name, i), 32'(got_q[i][27:16]), 32'(exp_q[i][27:16]));
      check($sformatf("%s_data%0d", name, i), 32'(got_q[i][15:0]), 32'(exp_q[i][15:0]));
    end
  endtask

  task automatic wait_busy_low(input string name, output int cycles);
    cycles = 0;
    while (pool_busy && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (pool_busy) check({name, "_timeout"}, 32'(pool_busy), 32'(0));
  endtask

  // Pulse run for one cycle; returns the number of cycles busy was high.
  task automatic run_job(input string name, output int bcycles);
    got_q.delete();
    pool_run = 1'b1;
    @(posedge clk); #1;
    check({name, "_busy_rise"}, 32'(pool_busy), 32'(1));
    pool_run = 1'b0;
    wait_busy_low(name, bcycles);
  endtask

  initial begin
    int bc, base, nm, n, waited;
    logic [15:0] hdr;

    tbl[0] = mk(16'h0004, 16'h0001, 16'h0000, 16'h0008, 16'h0004, 3, 16'h0002, 16'h0001, 16'h0002);
    tbl[1] = mk(16'h0002, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 2, 16'h0001, 16'h0001, 16'h0000);
    tbl[2] = mk(16'h0003, 16'h0004, 16'h0000, 16'h0007, 16'h0000, 2, 16'h0001, 16'h0000, 16'h0000);
    tbl[3] = mk(16'h0004, 16'h000F, 16'h000F, 16'h000F, 16'h000F, 3, 16'h0002, 16'h0003, 16'h0003);
    tbl[4] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[5] = mk(16'h0001, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[6] = mk(16'h0024, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[7] = mk(16'h0004, 16'hFFF0, 16'hFFF0, 16'h0002, 16'h0000, 3, 16'h0002, 16'h0000, 16'h0001);
    tbl[8] = mk(16'h0002, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 2, 16'h0001, 16'h0001, 16'h0000);

    clear_mem();
    reset = 1'b1;
    pool_run = 1'b0;
    #1;
    check("rst_busy", 32'(pool_busy), 32'(0));
    check("rst_rd_addr", 32'(pool_rd_address), 32'(0));
    check("rst_wr_addr", 32'(pool_wr_address), 32'(0));
    check("rst_wr_data", 32'(pool_wr_data), 32'(0));
    check("rst_wr_en", 32'(pool_wr_enable), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Table of single small maps with hand-computed results.
    for (int t = 0; t < 9; t++) begin
      clear_mem();
      in_mem[0] = tbl[t].hdr;
      if (tbl[t].nexp != 0) begin
        n = int'(tbl[t].hdr[4:0]);
        for (int i = 0; i < n; i++) in_mem[1 + i] = tbl[t].rows[i];
        in_mem[1 + n] = 16'hFFFF;
      end
      exp_q.delete();
      for (int k = 0; k < tbl[t].nexp; k++) add_exp(k, tbl[t].exp[k]);
      add_exp(tbl[t].nexp, 16'hFFFF);
      run_job($sformatf("tbl%0d", t), bc);
      compare_log($sformatf("tbl%0d", t));
      if (tbl[t].nexp == 0) check($sformatf("tbl%0d_term_busy_le4", t), 32'(bc <= 4), 32'(1));
    end

    // N=16, single set bit in the last row and column.
    clear_mem();
    in_mem[0] = 16'h0010;
    for (int i = 1; i <= 16; i++) in_mem[i] = 16'h0000;
    in_mem[16] = 16'h8000;
    exp_q.delete();
    add_exp(0, 16'h0008);
    for (int k = 1; k <= 7; k++) add_exp(k, 16'h0000);
    add_exp(8, 16'h0080);
    add_exp(9, 16'hFFFF);
    run_job("n16", bc);
    compare_log("n16");

    // Back-to-back N=8 and N=14 all-ones maps.
    clear_mem();
    in_mem[0] = 16'h0008;
    for (int i = 1; i <= 8; i++) in_mem[i] = 16'hFFFF;
    in_mem[9] = 16'h000E;
    for (int i = 10; i <= 23; i++) in_mem[i] = 16'hFFFF;
    exp_q.delete();
    add_exp(0, 16'h0004);
    for (int k = 1; k <= 4; k++) add_exp(k, 16'h000F);
    add_exp(5, 16'h0007);
    for (int k = 6; k <= 12; k++) add_exp(k, 16'h007F);
    add_exp(13, 16'hFFFF);
    run_job("b2b", bc);
    compare_log("b2b");

    // Odd N=5: last row and column are dropped.
    clear_mem();
    in_mem[0] = 16'h0005;
    in_mem[1] = 16'h0010; in_mem[2] = 16'h0010; in_mem[3] = 16'h0010;
    in_mem[4] = 16'h0010; in_mem[5] = 16'h001F;
    exp_q.delete();
    add_exp(0, 16'h0002); add_exp(1, 16'h0000); add_exp(2, 16'h0000); add_exp(3, 16'hFFFF);
    run_job("odd5", bc);
    compare_log("odd5");

    // Reset during the second pooled row of an N=16 map, then rerun.
    clear_mem();
    in_mem[0] = 16'h0010;
    for (int i = 1; i <= 16; i++) in_mem[i] = 16'($urandom);
    build_expected();
    got_q.delete();
    pool_run = 1'b1;
    @(posedge clk); #1;
    pool_run = 1'b0;
    waited = 0;
    while (got_q.size() < 2 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("mid_reset_reached_row1", 32'(got_q.size() >= 2), 32'(1));
    reset = 1'b1;
    #1;
    check("mid_reset_busy", 32'(pool_busy), 32'(0));
    check("mid_reset_rd_addr", 32'(pool_rd_address), 32'(0));
    check("mid_reset_wr_addr", 32'(pool_wr_address), 32'(0));
    check("mid_reset_wr_data", 32'(pool_wr_data), 32'(0));
    check("mid_reset_wr_en", 32'(pool_wr_enable), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_job("after_reset", bc);
    compare_log("after_reset");

    // Holding run through completion restarts from address 0.
    clear_mem();
    in_mem[0] = 16'h0004;
    in_mem[1] = 16'h0001; in_mem[2] = 16'h0000; in_mem[3] = 16'h0008; in_mem[4] = 16'h0004;
    build_expected();
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_q[i]);
    got_q.delete();
    pool_run = 1'b1;
    waited = 0;
    while (got_q.size() < 5 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    pool_run = 1'b0;
    check("hold_second_job_started", 32'(got_q.size() >= 5), 32'(1));
    wait_busy_low("hold", bc);
    compare_log("hold");

    // Randomized maps against the reference model.
    for (int t = 0; t < 20; t++) begin
      clear_mem();
      base = 0;
      nm = $urandom_range(1, 3);
      for (int m = 0; m < nm; m++) begin
        if ($urandom_range(0, 7) == 0) hdr = 16'($urandom) | 16'h0020;
        else hdr = 16'($urandom_range(0, 16));
        in_mem[base] = hdr;
        n = int'(hdr[4:0]);
        for (int i = 0; i < n; i++) in_mem[base + 1 + i] = 16'($urandom);
        base = base + 1 + n;
      end
      in_mem[base] = 16'hFFFF;
      build_expected();
      run_job($sformatf("rnd%0d", t), bc);
      compare_log($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_maxpool_stage.md
Name: binary_maxpool_stage

Overview:
Downstream stage of the binary 3x3 XNOR-convolution engine. It reads binary feature maps from that engine's output SRAM, applies 2x2 stride-2 max-pooling (bitwise OR over each 2x2 window), and writes the pooled maps to a second SRAM. It processes any number of back-to-back maps until it reads a terminator header, then writes a terminator and drops busy.

Parameters:
ADDR_W, 12, SRAM address width
DATA_W, 16, SRAM word width; also the maximum map width/height N
N_W, 5, width of the header dimension field (bits [N_W-1:0])

Ports:
clk  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high reset
pool_run  input  1  start pulse/level, sampled in IDLE only
pool_busy  output  1  high from the cycle after run is accepted until the end of the job
pool_rd_address  output  ADDR_W  input-SRAM read address (registered)
pool_rd_data  input  DATA_W  input-SRAM data, valid the cycle after its address
pool_wr_address  output  ADDR_W  output-SRAM write address (registered)
pool_wr_data  output  DATA_W  output-SRAM write data (registered)
pool_wr_enable  output  1  output-SRAM write strobe, one word per high cycle

Behaviour:
- Reset values: pool_busy=0, pool_rd_address=0, pool_wr_address=0, pool_wr_data=0, pool_wr_enable=0. FSM goes to IDLE. Reset mid-job abandons the job; the next run starts again at address 0 on both memories.
- Input memory format: header word at base address, N=bits[4:0] (row width = row count). N rows follow, one word per row; bit c is column c, and bits >=N are ignored.
- A header is a terminator if it is 0xFFFF, if bits[15:5]!=0, or if N<2.
- Odd N: the last row and the last column are discarded, giving P=floor(N/2).
- Output format: header word = P (upper bits 0), then P pooled rows, then a single 0xFFFF terminator after the last map.
- Pooled row r, bit j (j<P) = A[2j]|A[2j+1]|B[2j]|B[2j+1], where A=row 2r and B=row 2r+1. Bits >=P are 0.
- Addressing:
  - Input base starts at 0; next base = base+1+N.
  - Output base starts at 0; next base = base+1+P.
  - Output words are written at strictly consecutive addresses.
  - All address arithmetic wraps modulo 2^ADDR_W.
- FSM states: IDLE, HDR_RD, HDR_CHK, ROW_A, ROW_B, POOL_WR, TERM_WR.
  - IDLE: pool_run=1 -> HDR_RD, and pool_busy=1 next cycle.
  - HDR_RD: issue base address; wait one cycle for data.
  - HDR_CHK: terminator -> TERM_WR; otherwise write header P, then -> ROW_A.
  - ROW_A/ROW_B: read rows 2r and 2r+1, capturing each one cycle after its address.
  - POOL_WR: write pooled row r. If r<P-1 -> ROW_A; else -> HDR_RD for the next map.
  - TERM_WR: write 0xFFFF with pool_wr_enable for exactly one cycle -> IDLE; pool_busy falls the cycle after the terminator write.
- Throughput: each pooled row takes at most 4 cycles. Row-read addresses for row pair r+1 may overlap the write of row r.
- pool_run is ignored while busy. Holding pool_run high through completion starts a new job from address 0 one cycle after IDLE is re-entered.
- pool_wr_enable=0 in every state except header, row, and terminator writes. pool_wr_data holds its last value when not writing.
- No combinational path from any input to any output.

Test Plan:
- Input {0x0004, 0x0001, 0x0000, 0x0008, 0x0004, 0xFFFF}, pulse run -> writes addr0=0x0002, addr1=0x0001, addr2=0x0002, addr3=0xFFFF; busy falls; exactly 4 write strobes.
- N=16 map of all 0x0000 except row 15 = 0x8000 -> header 0x0008, rows 0..6 = 0x0000, row 7 = 0x0080, then 0xFFFF at addr 9.
- Back-to-back maps N=8 and N=14 (all-ones rows) then terminator -> out addr0=0x0004, addr1..4=0x000F, addr5=0x0007, addr6..12=0x007F, addr13=0xFFFF. Input second header read at addr 9.
- Odd N=5, rows 0x10,0x10,0x10,0x10,0x1F -> P=2, rows 0x0000,0x0000 (column 4 and row 4 dropped), then 0xFFFF.
- First header 0xFFFF (and separately 0x0001) -> single write 0xFFFF at addr0; busy high for at most 4 cycles.
- Assert reset during the second pooled row of an N=16 map -> all outputs return to 0 immediately. A new run rereads header at addr0 and rewrites the output from addr0 correctly.
